// File: rtl/tdc_event_reader.sv
// rtl/tdc_event_reader.sv - TDC channel event capture with clear handshake and FWFT event FIFO
module tdc_event_reader #(
    parameter int FIFO_DEPTH    = 4,
    parameter int CLEAR_TIMEOUT = 8,
    parameter int DROP_ON_FULL  = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 tdc_hasEvent,
    input  logic [31:0]                          tdc_timestamp,
    input  logic [31:0]                          tdc_timeOverThreshold,
    output logic                                 tdc_clear,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [31:0]                          out_timestamp,
    output logic [31:0]                          out_tot,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic [15:0]                          drop_count,
    output logic                                 clear_timeout_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(CLEAR_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CLEAR    = 2'd1,
        S_WAIT_LOW = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            clear_q, clear_d;
    logic            err_q, err_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [63:0]     mem_q [FIFO_DEPTH];
    logic [63:0]     head;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            drop;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Full is judged on the pre-edge count, so a pop in the same cycle never makes room for a capture.
    assign pop        = !fifo_empty && out_ready;

    // Next-state and capture decisions; clear pulse is registered from the next state.
    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
        drop_cnt_d = drop_cnt_q;
        push       = 1'b0;
        drop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && tdc_hasEvent) begin
                    if (!fifo_full) begin
                        push    = 1'b1;
                        state_d = S_CLEAR;
                    end else if (DROP_ON_FULL != 0) begin
                        drop    = 1'b1;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!tdc_hasEvent) begin
                    state_d = S_IDLE;
                end else if (tmo_cnt_q == TW'(CLEAR_TIMEOUT - 1)) begin
                    // The TDC ignored the clear; pulse it again without re-capturing.
                    err_d   = 1'b1;
                    state_d = S_CLEAR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        clear_d = (state_d == S_CLEAR);
    end

    // Handshake state, clear pulse and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tmo_cnt_q  <= '0;
            clear_q    <= 1'b0;
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            clear_q    <= clear_d;
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Event storage: {timestamp, tot} per entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tdc_timestamp, tdc_timeOverThreshold};
        end
    end

    assign head              = mem_q[rd_ptr_q];
    assign out_valid         = !fifo_empty;
    assign out_timestamp     = out_valid ? head[63:32] : 32'd0;
    assign out_tot           = out_valid ? head[31:0]  : 32'd0;
    assign fifo_count        = count_q;
    assign tdc_clear         = clear_q;
    assign drop_count        = drop_cnt_q;
    assign clear_timeout_err = err_q;

endmodule

// File: tb/tb_tdc_event_reader.sv
// tb/tb_tdc_event_reader.sv - directed self-checking bench for tdc_event_reader
module tb_tdc_event_reader;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        has_event;
    logic [31:0] ts_in;
    logic [31:0] tot_in;
    logic        out_ready;
    logic        sel;

    logic        clr0, clr1, val0, val1, err0, err1;
    logic [31:0] ts0, ts1, tot0, tot1;
    logic [2:0]  cnt0, cnt1;
    logic [15:0] drp0, drp1;

    logic        clr, val, err;
    logic [31:0] ots, otot;
    logic [2:0]  cnt;
    logic [15:0] drp;

    int n_checks;
    int n_fail;

    tdc_event_reader #(.FIFO_DEPTH(4), .CLEAR_TIMEOUT(8), .DROP_ON_FULL(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .tdc_hasEvent(has_event),
        .tdc_timestamp(ts_in), .tdc_timeOverThreshold(tot_in), .tdc_clear(clr0),
        .out_valid(val0), .out_ready(out_ready), .out_timestamp(ts0), .out_tot(tot0),
        .fifo_count(cnt0), .drop_count(drp0), .clear_timeout_err(err0)
    );

    tdc_event_reader #(.FIFO_DEPTH(4), .CLEAR_TIMEOUT(8), .DROP_ON_FULL(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .tdc_hasEvent(has_event),
        .tdc_timestamp(ts_in), .tdc_timeOverThreshold(tot_in), .tdc_clear(clr1),
        .out_valid(val1), .out_ready(out_ready), .out_timestamp(ts1), .out_tot(tot1),
        .fifo_count(cnt1), .drop_count(drp1), .clear_timeout_err(err1)
    );

    assign clr  = sel ? clr1 : clr0;
    assign val  = sel ? val1 : val0;
    assign err  = sel ? err1 : err0;
    assign ots  = sel ? ts1  : ts0;
    assign otot = sel ? tot1 : tot0;
    assign cnt  = sel ? cnt1 : cnt0;
    assign drp  = sel ? drp1 : drp0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_clear(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (clr) begin
                lat = i;
                break;
            end
        end
        check(tag, lat, exp_lat);
    endtask

    task automatic release_event();
        has_event = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_event(input logic [31:0] ts, input logic [31:0] tot);
        has_event = 1'b1;
        ts_in     = ts;
        tot_in    = tot;
        wait_clear("clr_latency", 1);
        release_event();
    endtask

    task automatic drain_expect(input string tag, input int first, input int last);
        out_ready = 1'b1;
        for (int i = first; i <= last; i++) begin
            check({tag, "_valid"}, val, 1);
            check({tag, "_ts"}, ots, i);
            check({tag, "_tot"}, otot, 32'd100 + i);
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_empty"}, val, 0);
        check({tag, "_count0"}, cnt, 0);
    endtask

    initial begin
        int   clr_seen;
        logic [31:0] mask;
        n_checks  = 0;
        n_fail    = 0;
        sel       = 1'b0;
        reset     = 1'b1;
        enable    = 1'b1;
        has_event = 1'b0;
        ts_in     = '0;
        tot_in    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_clear", clr, 0);
        check("rst_valid", val, 0);
        check("rst_count", cnt, 0);
        check("rst_drop", drp, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a clear handshake with two entries stored.
        send_event(32'h11, 32'h1);
        has_event = 1'b1;
        ts_in     = 32'h22;
        tot_in    = 32'h2;
        wait_clear("t1_clr", 1);
        check("t1_count2", cnt, 2);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("t1_async_clear", clr, 0);
        check("t1_async_valid", val, 0);
        check("t1_async_count", cnt, 0);
        check("t1_async_ts", ots, 0);
        check("t1_async_tot", otot, 0);
        tick();
        reset = 1'b0;
        tick();
        check("t1_idle_capture_clr", clr, 1);
        check("t1_idle_capture_cnt", cnt, 1);
        check("t1_idle_capture_ts", ots, 32'h22);
        release_event();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_drained", cnt, 0);

        // Single event with downstream ready.
        do_reset();
        out_ready = 1'b1;
        has_event = 1'b1;
        ts_in     = 32'h0000_1234;
        tot_in    = 32'd50;
        tick();
        check("t2_clr_n1", clr, 1);
        check("t2_valid_n1", val, 1);
        check("t2_ts", ots, 32'h0000_1234);
        check("t2_tot", otot, 32'd50);
        has_event = 1'b0;
        tick();
        check("t2_clr_off", clr, 0);
        check("t2_valid_off", val, 0);
        check("t2_count0", cnt, 0);
        out_ready = 1'b0;
        tick();

        // Full FIFO, event left pending in TDC.
        do_reset();
        sel = 1'b0;
        for (int i = 1; i <= 4; i++) send_event(i, 100 + i);
        check("t3_full", cnt, 4);
        has_event = 1'b1;
        ts_in     = 32'd5;
        tot_in    = 32'd105;
        clr_seen  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (clr) clr_seen++;
        end
        check("t3_no_clear_full", clr_seen, 0);
        check("t3_still_full", cnt, 4);
        check("t3_head_ts1", ots, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_after_pop_cnt", cnt, 3);
        check("t3_no_clear_same_cycle", clr, 0);
        tick();
        check("t3_late_clear", clr, 1);
        check("t3_refilled", cnt, 4);
        release_event();
        drain_expect("t3_order", 2, 5);

        // Full FIFO with drop enabled.
        sel = 1'b1;
        do_reset();
        for (int i = 1; i <= 4; i++) send_event(i, 100 + i);
        has_event = 1'b1;
        ts_in     = 32'd5;
        tot_in    = 32'd105;
        wait_clear("t4_drop_clr", 1);
        check("t4_drop_count", drp, 1);
        check("t4_count", cnt, 4);
        release_event();
        drain_expect("t4_order", 1, 4);
        check("t4_drop_held", drp, 1);

        // Clear ignored by the TDC: timeout and re-issued pulses.
        sel = 1'b0;
        do_reset();
        has_event = 1'b1;
        ts_in     = 32'hAAAA;
        tot_in    = 32'd7;
        mask      = '0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (clr) mask[k] = 1'b1;
            if (k == 9)  check("t5_err_before", err, 0);
            if (k == 10) check("t5_err_after", err, 1);
            if (k == 20) has_event = 1'b0;
        end
        check("t5_pulse_mask", mask, 32'h0008_0402);
        check("t5_one_entry", cnt, 1);
        check("t5_err_sticky", err, 1);
        check("t5_no_drop", drp, 0);

        // Enable gating; out_ready while empty is harmless.
        do_reset();
        enable    = 1'b0;
        out_ready = 1'b1;
        has_event = 1'b1;
        ts_in     = 32'h600D;
        tot_in    = 32'd9;
        clr_seen  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (clr) clr_seen++;
            if (cnt != 0) clr_seen++;
        end
        check("t6_blocked", clr_seen, 0);
        enable = 1'b1;
        tick();
        check("t6_clr", clr, 1);
        check("t6_valid", val, 1);
        check("t6_ts", ots, 32'h600D);
        release_event();
        check("t6_popped", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
